ddr_wr_burst_sched: RTL and testbench

//  Upstream feeder for the DDR write data path. Queues 8-beat x 64-bit write bursts from the host side.

---
 rtl/ddr_wr_burst_sched.sv | 141 ++++++++++++++
 tb/tb_ddr_wr_burst_sched.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_wr_burst_sched.sv
// ddr_wr_burst_sched: queues 8-beat x 64-bit write bursts and launches each
// one into the burst writer as an 8-cycle write window aligned to phase 0.
module ddr_wr_burst_sched #(
    parameter int DEPTH  = 4,
    parameter int WL_CYC = 8
) (
    input  logic                   clock2x,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [7:0][63:0]       req_data,
    output logic                   cmd_issue,
    output logic                   write,
    output logic [7:0][63:0]       DataHost,
    output logic                   burst_done,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(WL_CYC) + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [WW-1:0] WL_LOAD = WW'(WL_CYC - 1);

    typedef enum logic [1:0] {IDLE, WAIT_WL, ALIGN, BURST} state_t;

    state_t           state, state_n;
    logic [2:0]       phase;
    logic [WW-1:0]    wl_cnt, wl_n;
    logic             write_n, cmd_n, done_n, busy_n;

    logic [7:0][63:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0]    count_n;
    logic             push, pop;
    logic [7:0][63:0] head_n;

    // FIFO next-state: occupancy and the head value DataHost will present next cycle
    always_comb begin
        push     = req_valid & req_ready;
        rd_ptr_n = rd_ptr + AW'(pop);
        count_n  = fifo_count + CW'(push) - CW'(pop);
        // A push landing in a FIFO that is empty after this edge's pop becomes the new head.
        if (push && ((fifo_count - CW'(pop)) == '0)) begin
            head_n = req_data;
        end else if (count_n != '0) begin
            head_n = mem[rd_ptr_n];
        end else begin
            head_n = '0;
        end
    end

    // Burst payload storage
    always_ff @(posedge clock2x) begin
        if (push) begin
            mem[wr_ptr] <= req_data;
        end
    end

    // FIFO pointers, occupancy, ready and registered head payload
    always_ff @(posedge clock2x) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            req_ready  <= 1'b1;
            DataHost   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_ptr_n;
            fifo_count <= count_n;
            req_ready  <= (count_n != FULL);
            DataHost   <= head_n;
        end
    end

    // Scheduler next-state and registered-output values
    always_comb begin
        state_n = state;
        wl_n    = wl_cnt;
        write_n = write;
        cmd_n   = 1'b0;
        done_n  = 1'b0;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    cmd_n   = 1'b1;
                    wl_n    = WL_LOAD;
                    state_n = WAIT_WL;
                end
            end
            WAIT_WL: begin
                if (wl_cnt == '0) begin
                    state_n = ALIGN;
                end else begin
                    wl_n = wl_cnt - WW'(1);
                end
            end
            ALIGN: begin
                if (phase == 3'd7) begin
                    write_n = 1'b1;
                    state_n = BURST;
                end
            end
            BURST: begin
                if (phase == 3'd7) begin
                    write_n = 1'b0;
                    done_n  = 1'b1;
                    pop     = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // Scheduler state, free-running beat phase and registered outputs
    always_ff @(posedge clock2x) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= '0;
            wl_cnt     <= '0;
            write      <= 1'b0;
            cmd_issue  <= 1'b0;
            burst_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase + 3'd1;
            wl_cnt     <= wl_n;
            write      <= write_n;
            cmd_issue  <= cmd_n;
            burst_done <= done_n;
            busy       <= busy_n;
        end
    end
endmodule

// File: tb/tb_ddr_wr_burst_sched.sv
// tb_ddr_wr_burst_sched: randomized bench with a transaction-level timing model.
module tb_ddr_wr_burst_sched;
    localparam int DEPTH = 4;
    localparam int WL    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef logic [7:0][63:0] burst_t;

    logic clock2x = 1'b0;
    always #5 clock2x = ~clock2x;

    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    burst_t        req_data = '0;
    logic          req_ready, cmd_issue, write, burst_done, busy;
    burst_t        DataHost;
    logic [CW-1:0] fifo_count;

    logic          b_req_valid = 1'b0;
    burst_t        b_req_data = '0;
    logic          b_req_ready, b_cmd_issue, b_write, b_burst_done, b_busy;
    burst_t        b_DataHost;
    logic [CW-1:0] b_fifo_count;

    ddr_wr_burst_sched #(.DEPTH(DEPTH), .WL_CYC(WL)) dut (
        .clock2x(clock2x), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .cmd_issue(cmd_issue), .write(write), .DataHost(DataHost),
        .burst_done(burst_done), .fifo_count(fifo_count), .busy(busy)
    );

    ddr_wr_burst_sched #(.DEPTH(DEPTH), .WL_CYC(1)) dut_b (
        .clock2x(clock2x), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_data(b_req_data), .cmd_issue(b_cmd_issue), .write(b_write), .DataHost(b_DataHost),
        .burst_done(b_burst_done), .fifo_count(b_fifo_count), .busy(b_busy)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: queue of accepted bursts plus the cycle numbers of the
    // burst in flight. k counts cycles since reset; the writer's beat is k % 8.
    burst_t mq[$];
    int     k = 0;
    bit     m_active = 0;
    int     m_cmd = 0;
    int     m_start = 0;
    int     m_done = -1;
    bit     m_acc = 0;

    // Advance one clock; the model applies this edge's push/pop/launch rules.
    task automatic tick();
        bit start_new, do_pop;
        if (reset) begin
            m_acc = 0;
            @(posedge clock2x); #1;
            mq.delete();
            m_active = 0;
            m_done = -1;
            k = 0;
        end else begin
            start_new = !m_active && (mq.size() != 0);
            do_pop    = m_active && (k == m_start + 7);
            m_acc     = req_valid && (mq.size() != DEPTH);
            if (do_pop) begin
                void'(mq.pop_front());
                m_done = k + 1;
                m_active = 0;
            end
            if (m_acc) mq.push_back(req_data);
            if (start_new) begin
                m_active = 1;
                m_cmd    = k + 1;
                m_start  = ((k + 2 + WL + 7) / 8) * 8;
            end
            @(posedge clock2x); #1;
            k++;
        end
    endtask

    function automatic logic [CW+4:0] exp_status();
        logic e_write, e_cmd, e_done;
        e_write = m_active && (k >= m_start);
        e_cmd   = m_active && (k == m_cmd);
        e_done  = (k == m_done);
        return {e_write, e_cmd, e_done, m_active, (mq.size() != DEPTH), CW'(mq.size())};
    endfunction

    function automatic burst_t exp_data();
        return (mq.size() != 0) ? mq[0] : '0;
    endfunction

    function automatic burst_t rand_burst();
        burst_t r;
        for (int i = 0; i < 8; i++) r[i] = {$urandom, $urandom};
        return r;
    endfunction

    task automatic test_reset();
        int cmds = 0;
        reset = 1; req_valid = 0; b_req_valid = 0;
        for (int i = 0; i < 3; i++) tick();
        reset = 0;
        for (int n = 0; n <= 20; n++) begin
            if (n > 0) tick();
            if (cmd_issue) cmds++;
            checks++;
            if ({write, cmd_issue, burst_done, busy, req_ready, fifo_count} !== exp_status()) begin
                failures++;
                $display("FAIL reset_status k=%0d got=%b exp=%b", k,
                         {write, cmd_issue, burst_done, busy, req_ready, fifo_count}, exp_status());
            end
            checks++;
            if (DataHost !== exp_data()) begin
                failures++;
                $display("FAIL reset_data k=%0d got=%h exp=%h", k, DataHost, exp_data());
            end
        end
        checks++;
        if (cmds != 0) begin
            failures++;
            $display("FAIL reset_no_cmd got=%0d exp=0", cmds);
        end
        checks++;
        if (dut.phase !== 3'(k % 8)) begin
            failures++;
            $display("FAIL reset_phase got=%0d exp=%0d", dut.phase, k % 8);
        end
    endtask

    task automatic test_single_burst();
        burst_t pay, held;
        int push_k, cmd_k = -1, rise_k = -1, done_k = -1, wcnt = 0;
        bit stable = 1;
        for (int i = 0; i < 8; i++) pay[i] = 64'hA0 + 64'(i);
        req_valid = 1; req_data = pay; push_k = k;
        for (int n = 0; n < 60 && done_k < 0; n++) begin
            tick();
            req_valid = 0;
            checks++;
            if ({write, cmd_issue, burst_done, busy, req_ready, fifo_count} !== exp_status()) begin
                failures++;
                $display("FAIL single_status k=%0d got=%b exp=%b", k,
                         {write, cmd_issue, burst_done, busy, req_ready, fifo_count}, exp_status());
            end
            checks++;
            if (DataHost !== exp_data()) begin
                failures++;
                $display("FAIL single_data k=%0d got=%h exp=%h", k, DataHost, exp_data());
            end
            if (cmd_issue && cmd_k < 0) begin cmd_k = k; held = DataHost; end
            if (cmd_k >= 0 && busy && DataHost !== held) stable = 0;
            if (write) begin if (rise_k < 0) rise_k = k; wcnt++; end
            if (burst_done) done_k = k;
        end
        checks++;
        if (cmd_k != push_k + 2) begin
            failures++;
            $display("FAIL single_cmd_time got=%0d exp=%0d", cmd_k, push_k + 2);
        end
        checks++;
        if (rise_k % 8 != 0 || rise_k < cmd_k + WL + 1 || rise_k > cmd_k + WL + 8) begin
            failures++;
            $display("FAIL single_rise got=%0d exp=phase0 in [%0d,%0d]", rise_k, cmd_k + WL + 1, cmd_k + WL + 8);
        end
        checks++;
        if (wcnt != 8) begin
            failures++;
            $display("FAIL single_len got=%0d exp=8", wcnt);
        end
        checks++;
        if (done_k != rise_k + 8) begin
            failures++;
            $display("FAIL single_done got=%0d exp=%0d", done_k, rise_k + 8);
        end
        checks++;
        if (stable !== 1'b1 || held !== pay) begin
            failures++;
            $display("FAIL single_datahost got=%h exp=%h", held, pay);
        end
    endtask

    task automatic test_back_to_back();
        burst_t pays[5];
        int acc = 0, dones = 0;
        bit saw_full = 0;
        for (int i = 0; i < 5; i++) pays[i] = rand_burst();
        for (int n = 0; n < 400 && (acc < 5 || m_active || mq.size() != 0); n++) begin
            req_valid = (acc < 5);
            req_data  = pays[(acc < 5) ? acc : 4];
            tick();
            if (m_acc) acc++;
            req_valid = 0;
            checks++;
            if ({write, cmd_issue, burst_done, busy, req_ready, fifo_count} !== exp_status()) begin
                failures++;
                $display("FAIL b2b_status k=%0d got=%b exp=%b", k,
                         {write, cmd_issue, burst_done, busy, req_ready, fifo_count}, exp_status());
            end
            checks++;
            if (DataHost !== exp_data()) begin
                failures++;
                $display("FAIL b2b_data k=%0d got=%h exp=%h", k, DataHost, exp_data());
            end
            if (!req_ready) saw_full = 1;
            if (burst_done) dones++;
        end
        checks++;
        if (dones != 5) begin
            failures++;
            $display("FAIL b2b_done_count got=%0d exp=5", dones);
        end
        checks++;
        if (saw_full !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_low got=%0d exp=1", saw_full);
        end
    endtask

    task automatic test_collision();
        burst_t p[3];
        bit found = 0;
        for (int i = 0; i < 3; i++) p[i] = rand_burst();
        for (int i = 0; i < 2; i++) begin
            req_valid = 1; req_data = p[i];
            tick();
        end
        req_valid = 0;
        for (int n = 0; n < 60 && !found; n++) begin
            if (m_active && k == m_start + 7) found = 1;
            else tick();
        end
        checks++;
        if (!found || fifo_count !== CW'(2)) begin
            failures++;
            $display("FAIL collide_pre got=%0d exp=2 reached=%0d", fifo_count, found);
        end
        req_valid = 1; req_data = p[2];
        tick();
        req_valid = 0;
        checks++;
        if (burst_done !== 1'b1 || fifo_count !== CW'(2)) begin
            failures++;
            $display("FAIL collide_count done=%b got=%0d exp=2", burst_done, fifo_count);
        end
        for (int n = 0; n < 300 && (m_active || mq.size() != 0); n++) begin
            tick();
            checks++;
            if ({write, cmd_issue, burst_done, busy, req_ready, fifo_count} !== exp_status()) begin
                failures++;
                $display("FAIL collide_status k=%0d got=%b exp=%b", k,
                         {write, cmd_issue, burst_done, busy, req_ready, fifo_count}, exp_status());
            end
            checks++;
            if (DataHost !== exp_data()) begin
                failures++;
                $display("FAIL collide_data k=%0d got=%h exp=%h", k, DataHost, exp_data());
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int dones = 0;
        req_valid = 1; req_data = rand_burst();
        tick();
        req_valid = 0;
        for (int n = 0; n < 60 && !(m_active && k == m_start + 4); n++) tick();
        checks++;
        if (write !== 1'b1) begin
            failures++;
            $display("FAIL midreset_inburst got=%b exp=1", write);
        end
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if (dut.phase !== 3'd0) begin
            failures++;
            $display("FAIL midreset_phase got=%0d exp=0", dut.phase);
        end
        for (int n = 0; n <= 20; n++) begin
            if (n > 0) tick();
            if (burst_done) dones++;
            checks++;
            if ({write, cmd_issue, burst_done, busy, req_ready, fifo_count} !== exp_status()) begin
                failures++;
                $display("FAIL midreset_status k=%0d got=%b exp=%b", k,
                         {write, cmd_issue, burst_done, busy, req_ready, fifo_count}, exp_status());
            end
            checks++;
            if (DataHost !== exp_data()) begin
                failures++;
                $display("FAIL midreset_data k=%0d got=%h exp=%h", k, DataHost, exp_data());
            end
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL midreset_no_done got=%0d exp=0", dones);
        end
    endtask

    task automatic test_wl_min_align();
        burst_t pay;
        logic [63:0] bus [8];
        int push_k, cmd_k = -1, rise_k = -1, done_k = -1, nb = 0;
        for (int i = 0; i < 8; i++) begin
            pay[i] = 64'hA0 + 64'(i);
            bus[i] = '0;
        end
        for (int n = 0; n < 8 && (k % 8) != 4; n++) tick();
        b_req_valid = 1; b_req_data = pay; push_k = k;
        tick();
        b_req_valid = 0;
        for (int n = 0; n < 40 && done_k < 0; n++) begin
            if (b_cmd_issue && cmd_k < 0) cmd_k = k;
            if (b_write) begin
                if (rise_k < 0) rise_k = k;
                if (nb < 8) bus[nb] = b_DataHost[3'(k % 8)];
                nb++;
            end
            if (b_burst_done) done_k = k;
            if (done_k < 0) tick();
        end
        checks++;
        if (cmd_k != push_k + 2) begin
            failures++;
            $display("FAIL wl1_cmd_time got=%0d exp=%0d", cmd_k, push_k + 2);
        end
        checks++;
        if (rise_k != push_k + 4) begin
            failures++;
            $display("FAIL wl1_rise got=%0d exp=%0d", rise_k, push_k + 4);
        end
        checks++;
        if (nb != 8) begin
            failures++;
            $display("FAIL wl1_len got=%0d exp=8", nb);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus[i] !== 64'hA0 + 64'(i)) begin
                failures++;
                $display("FAIL wl1_bus beat=%0d got=%h exp=%h", i, bus[i], 64'hA0 + 64'(i));
            end
        end
        checks++;
        if (done_k != push_k + 12 || b_fifo_count !== '0 || b_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL wl1_done got=%0d exp=%0d count=%0d", done_k, push_k + 12, b_fifo_count);
        end
        tick();
        checks++;
        if (b_busy !== 1'b0 || b_write !== 1'b0) begin
            failures++;
            $display("FAIL wl1_idle busy=%b write=%b exp=0", b_busy, b_write);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_collision();
        test_reset_mid_burst();
        test_wl_min_align();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
